// File: rtl/uninasoc_irq_arbiter.sv
// PLIC gateway and priority arbiter with a claim/complete handshake and a level ext_irq_o.
// Optional build macro: UNINASOC_IRQ_ARB_SYNC_EN adds a 2-flop synchronizer on irq_src_i.
module uninasoc_irq_arbiter #(
    parameter int NUM_SRC    = 32,
    parameter int PRIO_WIDTH = 3,
    parameter int ID_WIDTH   = 5
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [NUM_SRC-1:0]             irq_src_i,
    input  logic [NUM_SRC-1:0]             edge_mode_i,
    input  logic [NUM_SRC-1:0]             enable_i,
    input  logic [NUM_SRC*PRIO_WIDTH-1:0]  priority_i,
    input  logic [PRIO_WIDTH-1:0]          threshold_i,
    input  logic                           claim_req_i,
    output logic                           claim_valid_o,
    output logic [ID_WIDTH-1:0]            claim_id_o,
    input  logic                           complete_valid_i,
    input  logic [ID_WIDTH-1:0]            complete_id_i,
    output logic                           ext_irq_o
);

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_e;

    gw_state_e               gw_q [NUM_SRC];
    logic [NUM_SRC-1:0]      irq_s;
    logic [NUM_SRC-1:0]      irq_prev_q;
    logic [NUM_SRC-1:0]      edge_seen_q;
    logic [NUM_SRC-1:0]      edge_s;
    logic [NUM_SRC-1:0]      new_req_s;
    logic [NUM_SRC-1:0]      claim_hit_s;
    logic [NUM_SRC-1:0]      complete_hit_s;
    logic [NUM_SRC-1:0]      eligible_s;
    logic                    take_s;
    logic [PRIO_WIDTH-1:0]   best_prio_s;
    logic [ID_WIDTH-1:0]     best_id_s;
    logic                    best_valid_s;
    logic [ID_WIDTH-1:0]     best_id_q;
    logic                    best_valid_q;
    logic                    claim_valid_q;
    logic [ID_WIDTH-1:0]     claim_id_q;

`ifdef UNINASOC_IRQ_ARB_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q;
    logic [NUM_SRC-1:0] sync2_q;

    // Two-stage synchronizer for asynchronous interrupt lines
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_src_i;
`endif

    assign edge_s    = irq_s & ~irq_prev_q;
    assign new_req_s = (edge_mode_i & edge_s) | (~edge_mode_i & irq_s);

    // Per-source claim/complete decode and eligibility
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            claim_hit_s[k]    = claim_req_i & best_valid_q & (best_id_q == ID_WIDTH'(k));
            complete_hit_s[k] = complete_valid_i & (k != 0) & (complete_id_i == ID_WIDTH'(k));
            eligible_s[k]     = (gw_q[k] == GW_PENDING) & enable_i[k]
                              & (priority_i[k*PRIO_WIDTH +: PRIO_WIDTH] > threshold_i);
        end
    end

    // Max-priority search; strict compare keeps the lowest ID on ties
    always_comb begin
        take_s       = 1'b0;
        best_prio_s  = '0;
        best_id_s    = '0;
        best_valid_s = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            take_s       = eligible_s[k] & (priority_i[k*PRIO_WIDTH +: PRIO_WIDTH] > best_prio_s);
            best_prio_s  = take_s ? priority_i[k*PRIO_WIDTH +: PRIO_WIDTH] : best_prio_s;
            best_id_s    = take_s ? ID_WIDTH'(k) : best_id_s;
            best_valid_s = best_valid_s | take_s;
        end
    end

    // Arbiter result, edge-detect history and claim response registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            irq_prev_q    <= '0;
            best_id_q     <= '0;
            best_valid_q  <= 1'b0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
        end else begin
            irq_prev_q    <= irq_s;
            best_id_q     <= best_id_s;
            best_valid_q  <= best_valid_s;
            claim_valid_q <= claim_req_i;
            if (claim_req_i) begin
                claim_id_q <= best_valid_q ? best_id_q : '0;
            end else begin
                claim_id_q <= claim_id_q;
            end
        end
    end

    // Gateway FSMs; an edge during INFLIGHT is remembered and re-arms the source on completion
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                gw_q[k]        <= GW_IDLE;
                edge_seen_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (k == 0) begin
                    gw_q[k]        <= GW_IDLE;
                    edge_seen_q[k] <= 1'b0;
                end else begin
                    case (gw_q[k])
                        GW_IDLE: begin
                            gw_q[k] <= new_req_s[k] ? GW_PENDING : GW_IDLE;
                        end
                        GW_PENDING: begin
                            gw_q[k] <= claim_hit_s[k] ? GW_INFLIGHT : GW_PENDING;
                        end
                        GW_INFLIGHT: begin
                            if (complete_hit_s[k]) begin
                                gw_q[k]        <= (edge_seen_q[k] | (edge_mode_i[k] & edge_s[k]))
                                                  ? GW_PENDING : GW_IDLE;
                                edge_seen_q[k] <= 1'b0;
                            end else if (edge_mode_i[k] & edge_s[k]) begin
                                edge_seen_q[k] <= 1'b1;
                            end else begin
                                edge_seen_q[k] <= edge_seen_q[k];
                            end
                        end
                        default: begin
                            gw_q[k]        <= GW_IDLE;
                            edge_seen_q[k] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign claim_valid_o = claim_valid_q;
    assign claim_id_o    = claim_id_q;
    assign ext_irq_o     = best_valid_q;

endmodule

// File: tb/tb_uninasoc_irq_arbiter.sv
// Directed self-checking bench for uninasoc_irq_arbiter (sync build selected by UNINASOC_IRQ_ARB_SYNC_EN).
module tb_uninasoc_irq_arbiter;

    localparam int NUM_SRC    = 32;
    localparam int PRIO_WIDTH = 3;
    localparam int ID_WIDTH   = 5;

    logic                           clock_i;
    logic                           reset_i;
    logic [NUM_SRC-1:0]             irq_src_i;
    logic [NUM_SRC-1:0]             edge_mode_i;
    logic [NUM_SRC-1:0]             enable_i;
    logic [NUM_SRC*PRIO_WIDTH-1:0]  priority_i;
    logic [PRIO_WIDTH-1:0]          threshold_i;
    logic                           claim_req_i;
    logic                           claim_valid_o;
    logic [ID_WIDTH-1:0]            claim_id_o;
    logic                           complete_valid_i;
    logic [ID_WIDTH-1:0]            complete_id_i;
    logic                           ext_irq_o;

    int tests_run = 0;
    int errors    = 0;

    uninasoc_irq_arbiter #(
        .NUM_SRC(NUM_SRC), .PRIO_WIDTH(PRIO_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .irq_src_i(irq_src_i),
        .edge_mode_i(edge_mode_i), .enable_i(enable_i), .priority_i(priority_i),
        .threshold_i(threshold_i), .claim_req_i(claim_req_i),
        .claim_valid_o(claim_valid_o), .claim_id_o(claim_id_o),
        .complete_valid_i(complete_valid_i), .complete_id_i(complete_id_i),
        .ext_irq_o(ext_irq_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic set_prio(input int k, input logic [PRIO_WIDTH-1:0] p);
        priority_i[k*PRIO_WIDTH +: PRIO_WIDTH] = p;
    endtask

    task automatic apply_reset(input string tag);
        reset_i          = 1'b1;
        irq_src_i        = '0;
        edge_mode_i      = '0;
        enable_i         = '1;
        priority_i       = '0;
        threshold_i      = 3'd0;
        claim_req_i      = 1'b0;
        complete_valid_i = 1'b0;
        complete_id_i    = 5'd0;
        #2;
        check_eq({tag, "_rst_ext"}, {31'd0, ext_irq_o}, 32'd0);
        check_eq({tag, "_rst_cv"}, {31'd0, claim_valid_o}, 32'd0);
        check_eq({tag, "_rst_id"}, {27'd0, claim_id_o}, 32'd0);
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic do_claim();
        claim_req_i = 1'b1;
        tick();
        claim_req_i = 1'b0;
    endtask

    task automatic do_complete(input logic [ID_WIDTH-1:0] id);
        complete_valid_i = 1'b1;
        complete_id_i    = id;
        tick();
        complete_valid_i = 1'b0;
        complete_id_i    = 5'd0;
    endtask

    task automatic pulse(input int k);
        irq_src_i[k] = 1'b1;
        tick();
        irq_src_i[k] = 1'b0;
        tick();
    endtask

    initial begin
`ifdef UNINASOC_IRQ_ARB_SYNC_EN
        // Synchronized build: 4-cycle source-to-ext_irq latency
        apply_reset("s6");
        set_prio(1, 3'd3);
        irq_src_i[1] = 1'b1;
        tick();
        check_eq("s6_lat1", {31'd0, ext_irq_o}, 32'd0);
        tick();
        tick();
        check_eq("s6_lat3", {31'd0, ext_irq_o}, 32'd0);
        tick();
        check_eq("s6_lat4", {31'd0, ext_irq_o}, 32'd1);
        do_claim();
        check_eq("s6_cv", {31'd0, claim_valid_o}, 32'd1);
        check_eq("s6_id", {27'd0, claim_id_o}, 32'd1);
`else
        // Level UART source: latency, claim, level-high completion re-pends
        apply_reset("t1");
        set_prio(4, 3'd3);
        irq_src_i[4] = 1'b1;
        tick();
        check_eq("t1_lat1", {31'd0, ext_irq_o}, 32'd0);
        tick();
        check_eq("t1_lat2", {31'd0, ext_irq_o}, 32'd1);
        do_claim();
        check_eq("t1_cv", {31'd0, claim_valid_o}, 32'd1);
        check_eq("t1_id", {27'd0, claim_id_o}, 32'd4);
        tick();
        check_eq("t1_cv_pulse", {31'd0, claim_valid_o}, 32'd0);
        check_eq("t1_id_hold", {27'd0, claim_id_o}, 32'd4);
        check_eq("t1_inflight_ext", {31'd0, ext_irq_o}, 32'd0);
        do_complete(5'd4);
        tick();
        check_eq("t1_repend_ext0", {31'd0, ext_irq_o}, 32'd0);
        tick();
        check_eq("t1_repend_ext1", {31'd0, ext_irq_o}, 32'd1);
        do_claim();
        check_eq("t1_id2", {27'd0, claim_id_o}, 32'd4);
        irq_src_i[4] = 1'b0;
        do_complete(5'd4);
        tick();
        tick();
        check_eq("t1_done_ext", {31'd0, ext_irq_o}, 32'd0);

        // Priority ties, priority change and threshold masking
        apply_reset("t2");
        set_prio(2, 3'd5);
        set_prio(3, 3'd5);
        irq_src_i[2] = 1'b1;
        irq_src_i[3] = 1'b1;
        tick();
        tick();
        check_eq("t2_ext", {31'd0, ext_irq_o}, 32'd1);
        do_claim();
        check_eq("t2_tie_id", {27'd0, claim_id_o}, 32'd2);
        do_complete(5'd2);
        set_prio(3, 3'd6);
        tick();
        tick();
        do_claim();
        check_eq("t2_prio_id", {27'd0, claim_id_o}, 32'd3);
        threshold_i = 3'd6;
        tick();
        tick();
        check_eq("t2_thr_ext", {31'd0, ext_irq_o}, 32'd0);
        do_claim();
        check_eq("t2_thr_cv", {31'd0, claim_valid_o}, 32'd1);
        check_eq("t2_thr_id", {27'd0, claim_id_o}, 32'd0);

        // Edge source: coalescing while PENDING, remembered edge while INFLIGHT
        apply_reset("t3");
        edge_mode_i[2] = 1'b1;
        set_prio(2, 3'd5);
        pulse(2);
        pulse(2);
        pulse(2);
        check_eq("t3_ext", {31'd0, ext_irq_o}, 32'd1);
        do_claim();
        check_eq("t3_id", {27'd0, claim_id_o}, 32'd2);
        tick();
        check_eq("t3_inflight_ext", {31'd0, ext_irq_o}, 32'd0);
        do_claim();
        check_eq("t3_coalesce_id", {27'd0, claim_id_o}, 32'd0);
        pulse(2);
        do_complete(5'd2);
        tick();
        check_eq("t3_reedge_ext", {31'd0, ext_irq_o}, 32'd1);
        do_claim();
        check_eq("t3_reedge_id", {27'd0, claim_id_o}, 32'd2);
        do_complete(5'd2);
        tick();
        check_eq("t3_idle_ext", {31'd0, ext_irq_o}, 32'd0);

        // Completions that must be ignored, empty claim
        apply_reset("t4");
        set_prio(3, 3'd5);
        do_complete(5'd3);
        do_complete(5'd0);
        check_eq("t4_ext_idle", {31'd0, ext_irq_o}, 32'd0);
        do_claim();
        check_eq("t4_empty_cv", {31'd0, claim_valid_o}, 32'd1);
        check_eq("t4_empty_id", {27'd0, claim_id_o}, 32'd0);
        irq_src_i[3] = 1'b1;
        tick();
        tick();
        check_eq("t4_pend_ext", {31'd0, ext_irq_o}, 32'd1);
        do_complete(5'd3);
        check_eq("t4_cmp_pend1", {31'd0, ext_irq_o}, 32'd1);
        tick();
        check_eq("t4_cmp_pend2", {31'd0, ext_irq_o}, 32'd1);
        irq_src_i[3] = 1'b0;
        do_claim();
        check_eq("t4_claim_id", {27'd0, claim_id_o}, 32'd3);

        // Asynchronous reset in the middle of a handshake
        apply_reset("t5");
        set_prio(1, 3'd5);
        irq_src_i[1] = 1'b1;
        tick();
        tick();
        do_claim();
        check_eq("t5_pre_cv", {31'd0, claim_valid_o}, 32'd1);
        claim_req_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        check_eq("t5_async_cv", {31'd0, claim_valid_o}, 32'd0);
        check_eq("t5_async_id", {27'd0, claim_id_o}, 32'd0);
        check_eq("t5_async_ext", {31'd0, ext_irq_o}, 32'd0);
        claim_req_i  = 1'b0;
        irq_src_i[1] = 1'b0;
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        tick();
        check_eq("t5_post_cv", {31'd0, claim_valid_o}, 32'd0);
        check_eq("t5_post_ext", {31'd0, ext_irq_o}, 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, errors);
        $finish;
    end

endmodule
